// File: rtl/line_memory_controller.sv
// Line-granular data-memory controller: line refill, full-line write-back and byte/half/word RMW writes.
// Latency: MEM_LATENCY+1 edges from accept to the response cycle for valid requests, next cycle for rejected ones.
// Backpressure: one request in flight, req_ready only in IDLE; response is an unstallable one-cycle pulse.
module line_memory_controller #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 16,
    parameter int MEM_DEPTH   = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [8*LINE_BYTES-1:0] req_line,
    output logic                    rsp_valid,
    output logic [8*LINE_BYTES-1:0] rsp_line,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [OFF_W:0] LB = (OFF_W+1)'(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Backing array; deliberately not reset so it maps onto plain storage.
    logic [LINE_W-1:0] mem [MEM_DEPTH];

    // Captured request.
    logic [2:0]        op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W:0]    size_q;
    logic [31:0]       wdata_q;
    logic [LINE_W-1:0] line_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] rsp_line_q;

    logic              accept;
    logic [OFF_W-1:0]  in_off;
    logic [OFF_W:0]    in_size;
    logic              in_err;
    logic              mem_we;
    logic [LINE_BYTES-1:0] byteena;
    logic [LINE_W-1:0] bit_mask;
    logic [LINE_W-1:0] wide;
    logic [LINE_W-1:0] shifted;
    logic [LINE_W-1:0] cur_line;
    logic [LINE_W-1:0] new_line;

    // Address bits above the array span alias away by design.
    logic unused_addr;
    assign unused_addr = ^(req_addr >> (OFF_W + IDX_W));

    assign in_off = req_addr[OFF_W-1:0];
    assign accept = req_valid && (state_q == IDLE);

    // Decode access size and reject reserved ops or partial writes spilling past the line end.
    always_comb begin
        in_size = '0;
        case (req_op)
            3'd1:    in_size = (OFF_W+1)'(1);
            3'd2:    in_size = (OFF_W+1)'(2);
            3'd3:    in_size = (OFF_W+1)'(4);
            default: in_size = '0;
        endcase
        in_err = (req_op > 3'd4) || (({1'b0, in_off} + in_size) > LB);
    end

    // Build the post-operation line: byte enables over [off, off+size), RMW merge of shifted data.
    always_comb begin
        byteena  = '0;
        bit_mask = '0;
        wide     = '0;
        cur_line = mem[idx_q];
        for (int k = 0; k < LINE_BYTES; k++) begin
            byteena[k] = (k >= int'(off_q)) && (k < int'(off_q) + int'(size_q));
            bit_mask[8*k +: 8] = {8{byteena[k]}};
        end
        wide[31:0] = wdata_q;
        shifted    = wide << {off_q, 3'b000};
        case (op_q)
            3'd1, 3'd2, 3'd3: new_line = (cur_line & ~bit_mask) | (shifted & bit_mask);
            3'd4:             new_line = line_q;
            default:          new_line = cur_line;
        endcase
    end

    assign mem_we = (state_q == WAIT) && (cnt_q == '0) && (op_q != 3'd0);

    // Array write at the end of the latency window; a reset before then leaves the array untouched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= new_line;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/response outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = in_err ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy = !req_ready;
    end

    // Request capture, latency countdown and response line register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            rsp_line_q <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            idx_q   <= req_addr[OFF_W +: IDX_W];
            off_q   <= in_off;
            size_q  <= in_size;
            wdata_q <= req_wdata;
            line_q  <= req_line;
            err_q   <= in_err;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            if (in_err) begin
                rsp_line_q <= '0;
            end
        end else if (state_q == WAIT) begin
            if (cnt_q == '0) begin
                rsp_line_q <= new_line;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign rsp_line = rsp_line_q;

endmodule

// File: tb/tb_line_memory_controller.sv
// Bench for line_memory_controller: directed scenarios plus randomized traffic.
// Expected values come from a byte-level memory model kept in the bench.
// Latency is counted in edges after the accept edge.
module tb_line_memory_controller;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [127:0] req_line;
    logic         rsp_valid;
    logic [127:0] rsp_line;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_model [64];

    line_memory_controller #(
        .ADDR_W(32), .LINE_BYTES(16), .MEM_DEPTH(64), .MEM_LATENCY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_line(req_line),
        .rsp_valid(rsp_valid), .rsp_line(rsp_line), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 16-byte lines, 64 lines, addresses wrap modulo 1024 bytes.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [127:0] ln, output logic [127:0] el, output logic ee);
        int idx;
        int o;
        int n;
        idx = int'((addr >> 4) & 32'd63);
        o   = int'(addr & 32'd15);
        n   = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : (op == 3'd3) ? 4 : 0;
        ee  = 1'b0;
        if (op > 3'd4) ee = 1'b1;
        else if (n > 0 && o + n > 16) ee = 1'b1;
        if (ee) begin
            el = '0;
        end else begin
            if (op == 3'd4) mem_model[idx] = ln;
            else for (int i = 0; i < n; i++) mem_model[idx][8*(o+i) +: 8] = wd[8*i +: 8];
            el = mem_model[idx];
        end
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [127:0] ln, input string tag, output logic [127:0] got);
        logic [127:0] el;
        logic         ee;
        int           lat;
        check({tag, "_ready_before"}, req_ready, 1'b1);
        req_op = op; req_addr = addr; req_wdata = wd; req_line = ln; req_valid = 1'b1;
        @(posedge clk); #1;
        model_apply(op, addr, wd, ln, el, ee);
        // Scramble the request fields: the controller must have captured them already.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_line  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, ee ? 0 : 2);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "_rsp_err"}, rsp_err, ee);
        check({tag, "_rsp_line"}, rsp_line, el);
        check({tag, "_ready_in_resp"}, req_ready, 1'b0);
        check({tag, "_busy_in_resp"}, busy, 1'b1);
        got = rsp_line;
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, rsp_valid, 1'b0);
        check({tag, "_ready_after"}, req_ready, 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_line_held"}, rsp_line, el);
    endtask

    localparam logic [127:0] LINE_INC = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        logic [127:0] got;
        logic [2:0]   rop;
        logic [31:0]  raddr;
        clk = 1'b0; reset_n = 1'b0; req_valid = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0; req_line = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", req_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_line", rsp_line, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Give every line a known value.
        for (int i = 0; i < 64; i++)
            do_req(3'd4, 32'(i * 16), 32'd0, {$urandom, $urandom, $urandom, $urandom}, "init", got);

        do_req(3'd4, 32'h20, 32'd0, LINE_INC, "wr_line", got);
        do_req(3'd0, 32'h2C, 32'd0, '0, "rd_line", got);
        check("rd_line_value", got, LINE_INC);

        do_req(3'd1, 32'h25, 32'hAB, '0, "wr_byte", got);
        check("wr_byte_value", got, 128'h0F0E0D0C0B0A09080706AB0403020100);

        do_req(3'd3, 32'h2C, 32'hDEADBEEF, '0, "wr_word", got);
        check("wr_word_value", got, 128'hDEADBEEF0B0A09080706AB0403020100);
        do_req(3'd3, 32'h2D, 32'h01020304, '0, "wr_word_cross", got);
        do_req(3'd0, 32'h20, 32'd0, '0, "rd_after_cross", got);
        check("rd_after_cross_value", got, 128'hDEADBEEF0B0A09080706AB0403020100);

        do_req(3'd2, 32'h2F, 32'h5555, '0, "wr_half_cross", got);
        do_req(3'd2, 32'h2E, 32'h1234, '0, "wr_half_edge", got);
        check("wr_half_edge_value", got, 128'h1234BEEF0B0A09080706AB0403020100);
        do_req(3'd6, 32'h20, 32'hFFFF_FFFF, '1, "reserved_op", got);

        do_req(3'd1, 32'h400, 32'h5A, '0, "alias_wr", got);
        do_req(3'd0, 32'h0, 32'd0, '0, "alias_rd", got);
        check("alias_rd_byte0", got[7:0], 8'h5A);

        // Reset during the last WAIT cycle of a word write: the write must be dropped.
        req_op = 3'd3; req_addr = 32'h20; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_in_wait", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_async_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_line", rsp_line, '0);
        @(posedge clk); #1;
        check("abort_no_pulse", rsp_valid, 1'b0);
        do_req(3'd0, 32'h20, 32'd0, '0, "abort_rd", got);
        check("abort_rd_value", got, 128'h1234BEEF0B0A09080706AB0403020100);

        // Randomized traffic over a few lines, including aliases and all ops.
        for (int t = 0; t < 200; t++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                  | 32'($urandom_range(0, 15));
            do_req(rop, raddr, $urandom, {$urandom, $urandom, $urandom, $urandom}, "rand", got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
